wdata_router: RTL
=================

WDATA_ROUTER -- requirements
Module: wdata_router

Interface
REQ-001 SHALL have parameter DEPTH, default 4: outstanding-AW FIFO entries, power of two, 2..8.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have inputs S0_AWFire, S1_AWFire, DS_AWFire, 1 each: accepted write-address handshake (Valid&Ready) toward IM, DM and the default slave.
REQ-005 SHALL have input AWLen_in, `AXI_LEN_BITS: burst length of the accepted AW (beats-1).
REQ-006 SHALL have output AW_Block, 1: high when the FIFO is full, so that upstream gates M1_AWValid/M1_AWReady.
REQ-007 SHALL have inputs M1_WData (`AXI_DATA_BITS), M1_WStrb (`AXI_STRB_BITS), M1_WLast (1) and M1_WValid (1), plus output M1_WReady (1): the master-1 W channel.
REQ-008 SHALL have, for X in {S0,S1,DS}, outputs X_WData, X_WStrb, X_WLast and X_WValid, plus input X_WReady: the slave W channels.
REQ-009 SHALL have output W_Err, 1: protocol-error pulse.
REQ-010 SHALL have output Level, $clog2(DEPTH)+1: FIFO occupancy.

Function
REQ-011 SHALL push {target, AWLen_in} on any cycle with exactly one AWFire high and the FIFO not full; target encoding: 0=S0, 1=S1, 2=DS.
REQ-012 SHALL ignore a push attempted while full; the bench flags this as a violation of the AW_Block contract.
REQ-013 SHALL ignore all AWFire inputs when more than one is high in the same cycle, and pulse W_Err the next cycle.
REQ-014 SHALL drive AW_Block = (Level==DEPTH), combinational from registered state.
REQ-015 SHALL route nothing while the FIFO is empty: all X_WValid=0 and M1_WReady=0.
REQ-016 SHALL, when the FIFO is non-empty, drive the selected slave with sel_WValid=M1_WValid and M1_WReady=sel_WReady; unselected X_WValid=0.
REQ-017 SHALL broadcast WData and WStrb to all slaves unchanged.
REQ-018 SHALL provide no push-to-route bypass: an entry pushed in cycle N routes no earlier than cycle N+1.
REQ-019 SHALL keep a beat counter (`AXI_LEN_BITS) that increments on each W fire (M1_WValid&M1_WReady).
REQ-020 SHALL drive X_WLast = (beat counter == head len), generated internally; M1_WLast is not forwarded.
REQ-021 SHALL, on a W fire with counter==head len, pop the head and clear the counter to 0 in the same edge.
REQ-022 SHALL, on a W fire where M1_WLast != (counter==head len), pulse W_Err high for exactly one cycle, registered, in the next cycle; routing is unaffected.
REQ-023 SHALL, on simultaneous push and pop, perform both, leave Level unchanged, and write the new entry correctly even at Level==DEPTH (pop frees the slot in the same cycle).
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL make a single-beat burst (len=0) pop on its first fire with X_WLast=1.
REQ-026 SHALL hold X_WValid, data and the counter stable while sel_WReady=0.

Reset
REQ-027 SHALL, on rst high at a clock edge, empty the FIFO (pointers 0, Level=0), set counter=0 and W_Err=0, and as a result drive AW_Block=0, all X_WValid=0 and M1_WReady=0.
REQ-028 SHALL abandon any mid-burst state on reset; beats after reset route only to entries pushed after reset.
REQ-029 SHALL ignore pushes in a cycle where rst is high.

Verification
REQ-030 SHALL cover: S1_AWFire with AWLen_in=3, then 4 W beats with S1_WReady=1 and WLast on the 4th -> S1_WValid on beats 1-4, S1_WLast only on the 4th, pop, Level back to 0, W_Err=0.
REQ-031 SHALL cover: pushes of S0 (len 0), DS (len 1) and S1 (len 0) back-to-back with W held valid -> beats routed S0, DS, DS, S1 in order, each WLast correct.
REQ-032 SHALL cover: DEPTH=4 pushes -> AW_Block=1, Level=4; then a W-fire pop together with a push -> Level stays 4, and the new entry is routed last.
REQ-033 SHALL cover: len=1 burst with M1_WLast=1 on the 1st beat -> W_Err pulses one cycle, the burst still completes after 2 beats.
REQ-034 SHALL cover: rst asserted after the 2nd beat of a len=3 burst -> next cycle Level=0, all valids 0; a new S0 len=0 burst then completes normally.
REQ-035 SHALL cover: S0_AWFire and S1_AWFire high together -> no push, W_Err=1 next cycle.

Source files
------------

// File: rtl/wdata_router.sv
// wdata_router
// Routes the master-1 AXI write-data channel to one of three slaves
// (S0 = IM, S1 = DM, DS = default slave) in the order their write
// addresses were accepted. Each accepted AW pushes {target, len} into a
// small FIFO. The head entry selects the W destination. A beat counter
// generates WLast locally and pops the head on the final beat.
//
// Ports
//   clk, rst                 : clock; synchronous active-high reset
//   S0/S1/DS_AWFire          : accepted AW handshake toward each slave
//   AWLen_in                 : burst length (beats-1) of the accepted AW
//   AW_Block                 : FIFO full, so upstream must stall AW
//   M1_W*                    : master-1 W channel (WLast only checked)
//   S0/S1/DS_W*              : slave W channels
//   W_Err                    : registered one-cycle protocol-error pulse
//   Level                    : FIFO occupancy

`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module wdata_router #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       S0_AWFire,
    input  logic                       S1_AWFire,
    input  logic                       DS_AWFire,
    input  logic [`AXI_LEN_BITS-1:0]   AWLen_in,
    output logic                       AW_Block,
    input  logic [`AXI_DATA_BITS-1:0]  M1_WData,
    input  logic [`AXI_STRB_BITS-1:0]  M1_WStrb,
    input  logic                       M1_WLast,
    input  logic                       M1_WValid,
    output logic                       M1_WReady,
    output logic [`AXI_DATA_BITS-1:0]  S0_WData,
    output logic [`AXI_STRB_BITS-1:0]  S0_WStrb,
    output logic                       S0_WLast,
    output logic                       S0_WValid,
    input  logic                       S0_WReady,
    output logic [`AXI_DATA_BITS-1:0]  S1_WData,
    output logic [`AXI_STRB_BITS-1:0]  S1_WStrb,
    output logic                       S1_WLast,
    output logic                       S1_WValid,
    input  logic                       S1_WReady,
    output logic [`AXI_DATA_BITS-1:0]  DS_WData,
    output logic [`AXI_STRB_BITS-1:0]  DS_WStrb,
    output logic                       DS_WLast,
    output logic                       DS_WValid,
    input  logic                       DS_WReady,
    output logic                       W_Err,
    output logic [$clog2(DEPTH):0]     Level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int LEN_W   = `AXI_LEN_BITS;
    localparam int NUM_SLV = 3;

    // FIFO storage: small enough to live in registers so the head entry is
    // available combinationally for routing.
    logic [1:0]         tgt_mem [DEPTH];
    logic [LEN_W-1:0]   len_mem [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;
    logic [LEN_W-1:0]   beat_reg;
    logic               err_reg;

    logic               fifo_empty;
    logic               fifo_full;
    logic [1:0]         head_tgt;
    logic [LEN_W-1:0]   head_len;
    logic               burst_last;
    logic               w_fire;
    logic               pop;
    logic               push;
    logic [2:0]         aw_vec;
    logic               aw_single;
    logic               aw_multi;
    logic [1:0]         push_tgt;
    logic               err_next;

    logic [NUM_SLV-1:0] slave_ready;
    logic [NUM_SLV-1:0] slave_sel;
    logic [NUM_SLV-1:0] slave_valid;

    assign fifo_empty = (level_reg == '0);
    assign fifo_full  = (level_reg == LVL_W'(DEPTH));
    assign head_tgt   = tgt_mem[rd_ptr_reg];
    assign head_len   = len_mem[rd_ptr_reg];
    assign burst_last = (beat_reg == head_len);

    assign slave_ready = {DS_WReady, S1_WReady, S0_WReady};

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slave_sel
            assign slave_sel[gi]   = !fifo_empty && (head_tgt == 2'(gi));
            assign slave_valid[gi] = slave_sel[gi] && M1_WValid;
        end
    endgenerate

    assign M1_WReady = |(slave_sel & slave_ready);
    assign w_fire    = M1_WValid && M1_WReady;
    assign pop       = w_fire && burst_last;

    // Exactly-one-hot AW fire pushes; several at once is a protocol error.
    assign aw_vec    = {DS_AWFire, S1_AWFire, S0_AWFire};
    assign aw_single = (aw_vec == 3'b001) || (aw_vec == 3'b010) || (aw_vec == 3'b100);
    assign aw_multi  = (aw_vec != 3'b000) && !aw_single;

    // A pop in the same cycle frees the head slot, so a push is still legal
    // when full (write pointer equals read pointer in that case).
    assign push = aw_single && (!fifo_full || pop) && !rst;

    always_comb begin
        push_tgt = 2'd0;
        if (S1_AWFire) begin
            push_tgt = 2'd1;
        end else if (DS_AWFire) begin
            push_tgt = 2'd2;
        end
    end

    // WLast mismatch only matters on an actual beat transfer.
    assign err_next = aw_multi || (w_fire && (M1_WLast != burst_last));

    always_ff @(posedge clk) begin
        if (push) begin
            tgt_mem[wr_ptr_reg] <= push_tgt;
            len_mem[wr_ptr_reg] <= AWLen_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            beat_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
            if (pop) begin
                beat_reg <= '0;
            end else if (w_fire) begin
                beat_reg <= beat_reg + LEN_W'(1);
            end
            err_reg <= err_next;
        end
    end

    assign AW_Block = fifo_full;
    assign Level    = level_reg;
    assign W_Err    = err_reg;

    assign S0_WValid = slave_valid[0];
    assign S1_WValid = slave_valid[1];
    assign DS_WValid = slave_valid[2];

    assign S0_WLast = !fifo_empty && burst_last;
    assign S1_WLast = !fifo_empty && burst_last;
    assign DS_WLast = !fifo_empty && burst_last;

    assign S0_WData = M1_WData;
    assign S1_WData = M1_WData;
    assign DS_WData = M1_WData;
    assign S0_WStrb = M1_WStrb;
    assign S1_WStrb = M1_WStrb;
    assign DS_WStrb = M1_WStrb;

endmodule
